seg7_scan_driver: RTL

Time-multiplexed driver for the 8-digit common-anode 7-segment display. KeyScan holds a single static chip-select chosen by button; this block scans all eight digits continuously. It holds an 8-entry digit buffer written by upstream logic (key handling, counters) and outputs the same cs / o_dig_sel signal pair the board expects. Digit cycling uses inter-digit blanking to suppress ghosting, and a frame-coherent shadow buffer prevents tearing.

---
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scan driver with inter-digit blanking
// and a frame-coherent shadow buffer. Optional leading-zero blanking: define SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int F_CLK     = 50000000,
    parameter int F_SCAN    = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [7:0] cs,
    output logic [7:0] o_dig_sel,
    output logic       frame_done
);

    localparam int DIV = F_CLK / F_SCAN;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_SHOW = PW'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [4:0]    buf_q    [8];
    logic [4:0]    buf_d    [8];
    logic [4:0]    shadow_q [8];
    logic [4:0]    shadow_d [8];
    logic [7:0]    cs_q, cs_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic          pre_wrap;
    logic          frame_wrap;
`ifdef SEG7_LZB_EN
    logic [7:0]    blank_q, blank_d;
    logic          lz_run;
`endif

    function automatic logic [7:0] seg_decode(input logic [4:0] d);
        logic [7:0] s;
        case (d[3:0])
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        if (d[4]) s[7] = 1'b0;
        return s;
    endfunction

    assign pre_wrap   = (pre_q == PRE_LAST);
    assign frame_wrap = pre_wrap && (ptr_q == 3'd7);

    // Slot timing and the BLANK/SHOW state machine.
    always_comb begin
        pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
        ptr_d   = pre_wrap ? ptr_q + 3'd1 : ptr_q;
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (pre_d == PRE_SHOW) state_d = ST_SHOW;
            ST_SHOW:  if (pre_wrap)          state_d = ST_BLANK;
            default:                         state_d = ST_BLANK;
        endcase
    end

    // wr_en is a plain strobe with no back-pressure: every asserted cycle writes.
    // The shadow copies the pre-write buffer on the frame wrap edge.
    always_comb begin
        buf_d    = buf_q;
        shadow_d = shadow_q;
        if (wr_en) buf_d[wr_addr] = wr_data;
        if (frame_wrap) shadow_d = buf_q;
    end

`ifdef SEG7_LZB_EN
    // Blank mask tracks the shadow: bit k set when digits 7..k are all 5'h00.
    always_comb begin
        blank_d = blank_q;
        lz_run  = 1'b1;
        if (frame_wrap) begin
            for (int k = 7; k >= 1; k--) begin
                lz_run     = lz_run && (buf_q[k] == 5'h00);
                blank_d[k] = lz_run;
            end
            blank_d[0] = 1'b0;
        end
    end
`endif

    // Outputs are derived from next-state values so they change on the same edge as the prescaler.
    always_comb begin
        cs_d         = 8'hFF;
        seg_d        = 8'hFF;
        frame_done_d = frame_wrap;
        if (state_d == ST_SHOW) begin
            cs_d  = ~(8'h01 << ptr_d);
            seg_d = seg_decode(shadow_d[ptr_d]);
`ifdef SEG7_LZB_EN
            if (blank_d[ptr_d]) seg_d = 8'hFF;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            pre_q        <= '0;
            ptr_q        <= '0;
            cs_q         <= 8'hFF;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
`ifdef SEG7_LZB_EN
            blank_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            ptr_q        <= ptr_d;
            cs_q         <= cs_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            buf_q        <= buf_d;
            shadow_q     <= shadow_d;
`ifdef SEG7_LZB_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign cs         = cs_q;
    assign o_dig_sel  = seg_q;
    assign frame_done = frame_done_q;

endmodule
